gray_ptr_sync: RTL

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

---
 rtl/sync_pkg.sv | 32 +++
 rtl/sync_chain.sv | 60 ++++++
 rtl/gray_ptr_sync.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// ----------------------------------------------------------------------------
// sync_pkg
//   Shared helpers for the multi-bit pointer synchronizers.
//   - gray2bin / bin2gray operate on a fixed SYNC_MAX_WIDTH-bit word. Callers
//     zero-extend narrower buses. The high bits of a zero-extended Gray word
//     decode to zero, so the low bits of the result are the correct binary
//     value for the narrower bus.
//   - SYNC_STAGES_MIN / SYNC_STAGES_MAX bound the synchronizer depth.
// ----------------------------------------------------------------------------
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int SYNC_MAX_WIDTH  = 64;

    typedef logic [SYNC_MAX_WIDTH-1:0] sync_word_t;

    // MSB passes straight through; every lower bit folds in all bits above it.
    function automatic sync_word_t gray2bin(input sync_word_t g);
        sync_word_t b;
        b[SYNC_MAX_WIDTH-1] = g[SYNC_MAX_WIDTH-1];
        for (int i = SYNC_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic sync_word_t bin2gray(input sync_word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//   Plain STAGES-deep flop chain for bringing an asynchronous bus into the clk
//   domain. The stages are wired flop-to-flop with nothing in between, which
//   keeps the metastability settling time of each stage intact.
//
//   Parameters: WIDTH  - bus width
//               STAGES - chain depth, SYNC_STAGES_MIN..SYNC_STAGES_MAX
//   Ports:      clk    - destination clock
//               rst_n  - asynchronous active-low reset, clears every stage
//               d      - asynchronous input bus
//               q      - output of the last stage
// ----------------------------------------------------------------------------
module sync_chain
    import sync_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("sync_chain: STAGES=%0d outside %0d..%0d",
                   STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync
//   Synchronizes a (normally Gray-coded) pointer bus into the clk domain,
//   decodes it to binary, and reports change / stability status.
//
//   Parameters: WIDTH         - bus width (1..64)
//               STAGES        - synchronizer depth (2..4)
//               GRAY_IN       - 1: din is Gray coded and decoded; 0: passthrough
//               STABLE_CYCLES - quiet cycles before 'stable' asserts (>= 1)
//   Ports:      clk           - destination clock
//               rst_n         - asynchronous active-low reset
//               din           - source-domain registered bus
//               q_sync        - last synchronizer stage
//               q_bin         - registered decoded value (one edge after q_sync)
//               chg           - one-cycle pulse on each new q_bin value
//               stable        - q_bin unchanged for STABLE_CYCLES cycles
//               err_multibit  - sticky flag: q_sync moved by more than one bit
//
//   Optional macro SYNC_ASSERT_EN: when defined (and GRAY_IN=1) the multi-bit
//   change checker is built; otherwise err_multibit is constant 0.
// ----------------------------------------------------------------------------
module gray_ptr_sync
    import sync_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int STAGES        = 2,
    parameter int GRAY_IN       = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q_sync,
    output logic [WIDTH-1:0] q_bin,
    output logic             chg,
    output logic             stable,
    output logic             err_multibit
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    generate
        if (WIDTH < 1 || WIDTH > SYNC_MAX_WIDTH) begin : g_bad_width
            $error("gray_ptr_sync: WIDTH=%0d outside 1..%0d", WIDTH, SYNC_MAX_WIDTH);
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("gray_ptr_sync: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Synchronizer chain
    // ------------------------------------------------------------------
    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (q_sync)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_bin_next;

    generate
        if (GRAY_IN != 0) begin : g_decode
            sync_word_t gray_wide;
            sync_word_t bin_wide;
            assign gray_wide  = sync_word_t'(q_sync);
            assign bin_wide   = gray2bin(gray_wide);
            assign q_bin_next = bin_wide[WIDTH-1:0];
            // Bits above WIDTH decode from zero-extension and are always 0.
            if (WIDTH < SYNC_MAX_WIDTH) begin : g_hi
                logic unused_bin_hi;
                assign unused_bin_hi = ^bin_wide[SYNC_MAX_WIDTH-1:WIDTH];
            end
        end else begin : g_pass
            assign q_bin_next = q_sync;
        end
    endgenerate

    // ------------------------------------------------------------------
    // q_bin / chg / quiet counter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_bin_reg;
    logic             chg_reg;
    logic             chg_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The counter is cleared in the same edge that raises chg, so the
    // counter already reads 0 during the chg cycle and stable drops with it.
    always_comb begin
        chg_next = (q_bin_next != q_bin_reg);
        cnt_next = cnt_reg;
        if (chg_next) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bin_reg <= '0;
            chg_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            q_bin_reg <= q_bin_next;
            chg_reg   <= chg_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign q_bin  = q_bin_reg;
    assign chg    = chg_reg;
    assign stable = (cnt_reg == CNT_MAX);

    // ------------------------------------------------------------------
    // Gray-violation checker
    // ------------------------------------------------------------------
`ifdef SYNC_ASSERT_EN
    generate
        if (GRAY_IN != 0) begin : g_checker
            logic [WIDTH-1:0] q_sync_prev_reg;
            logic [WIDTH-1:0] q_diff;
            logic             multibit;
            logic             err_reg;

            assign q_diff = q_sync ^ q_sync_prev_reg;
            // x & (x-1) clears the lowest set bit; anything left means >1 bit.
            assign multibit = |(q_diff & (q_diff - WIDTH'(1)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_sync_prev_reg <= '0;
                    err_reg         <= 1'b0;
                end else begin
                    q_sync_prev_reg <= q_sync;
                    err_reg         <= err_reg | multibit;
                end
            end

            assign err_multibit = err_reg;
        end else begin : g_no_checker
            assign err_multibit = 1'b0;
        end
    endgenerate
`else
    assign err_multibit = 1'b0;
`endif

endmodule
